ram_dp_arbiter: RTL and testbench
=================================

Name: ram_dp_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 simple dual-port peripheral RAM.
  - The RAM has one write port, one read port and a 1-cycle registered read.
- Arbitrates the write port and the read port independently, round-robin per port.
- Registers the winning commands into the RAM and returns read data tagged to the requester that issued the read.
- Forwards write data when a read and a write hit the same address in the same RAM cycle.
- Sits between two peripheral bus masters (A, B) and the RAM instance.

Parameters:
- ADDR_W, 8, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM data width

Ports:
- AClkH  in  1  clock; all state on rising edge
- AResetH  in  1  synchronous reset, active-high
- AClkHEn  in  1  clock enable; state advances only when 1
- AReqA  in  1  requester A command valid; held with Wr/Addr/Mosi until AAckA
- AWrA  in  1  A: 1=write, 0=read
- AAddrA  in  ADDR_W  A address
- AMosiA  in  DATA_W  A write data
- AAckA  out  1  A command accepted this cycle (combinational)
- AMisoA  out  DATA_W  A read data; 0 when AMisoVldA=0
- AMisoVldA  out  1  A read data valid (1-cycle pulse)
- AReqB, AWrB, AAddrB, AMosiB, AAckB, AMisoB, AMisoVldB: same as A, for requester B
- ARamAddrWr  out  ADDR_W  to RAM write address
- ARamMosi  out  DATA_W  to RAM write data
- ARamWrEn  out  1  to RAM write enable
- ARamAddrRd  out  ADDR_W  to RAM read address
- ARamMiso  in  DATA_W  from RAM read data (valid 1 cycle after ARamAddrRd sampled)

Behaviour:
- Clocking and reset:
  - Single clock AClkH. Reset is synchronous and active-high on AResetH.
  - Reset clears all registers:
    - ARamWrEn=0, ARamAddrWr=0, ARamMosi=0, ARamAddrRd=0
    - AMisoVldA/B=0, AMisoA/B=0
    - bypass flag=0, read tags=0
    - WrLast=B, RdLast=B, so A wins the first contention on each port.
  - AAckA/B=0 while AResetH=1.
- Arbitration (combinational, only when AClkHEn=1 and AResetH=0):
  - Write candidates: AReqX & AWrX. Read candidates: AReqX & ~AWrX.
  - Per port: one candidate -> grant it. Two candidates -> grant the requester not equal to that port's Last.
  - On any grant, Last for that port <= the granted requester.
  - A write grant and a read grant may occur in the same cycle, to different requesters (A writes while B reads, or vice versa).
  - AAckX=1 in the grant cycle only. The requester may change its command in the next cycle.
  - A requester with Req held and not granted keeps waiting. The fairness bound is 1 lost arbitration.
- Command stage (cycle after Ack, T+1):
  - Write granted at T: ARamWrEn=1, with ARamAddrWr/ARamMosi from the winner, for exactly one cycle. Otherwise ARamWrEn=0, and address/data hold their last values.
  - Read granted at T: ARamAddrRd <= winner address; rd_vld1 <= 1; tag1 <= winner.
- Return stage (T+2):
  - AMisoVldX=1 for tag1=X, with AMisoX = bypass ? saved write data : ARamMiso.
  - Total read latency from AAck to AMisoVld is 2 enabled cycles.
  - Back-to-back reads are fully pipelined: one per cycle.
- Collision bypass:
  - Condition: in the command stage, ARamWrEn=1 and a read is issued with ARamAddrRd == ARamAddrWr.
  - Action: set bypass and save ARamMosi; the returned data is the new data.
  - Write-then-read of the same address in consecutive grants needs no bypass; the RAM already holds the data.
- AClkHEn=0:
  - All registers hold. AAck=0. ARamWrEn forced 0. AMisoVld forced 0.
  - ARamAddrRd stays stable, so ARamMiso is unchanged.
  - The pending return resumes on the next enabled cycle, with the same data.
- Reset mid-operation:
  - Any in-flight read is discarded with no AMisoVld pulse.
  - A command registered but not yet written is dropped (ARamWrEn=0).

Test Plan:
- After reset, A write 0x10<-0x5A alone -> AAckA at T, ARamWrEn=1 with addr 0x10, data 0x5A at T+1; A read 0x10 -> AMisoVldA at T+2 with AMisoA=0x5A.
- A and B both request write (0x01<-0x11, 0x02<-0x22) held -> A acked first, B acked next cycle; repeat with both held -> grants alternate B, A, B.
- A writes 0x20<-0xC3 while B reads 0x20 in the same cycle -> both acked; AMisoB=0xC3 (bypass) with AMisoVldB at T+2.
- A reads 0x30, 0x31, 0x32 back-to-back while B reads 0x40 contending -> AMisoVldA/B pulses carry correct data and tags, one return per cycle, latency 2 each.
- AClkHEn low for 3 cycles between a read Ack and its return -> no Ack or Vld while low; AMisoVld arrives with the correct data on the 2nd enabled cycle.
- AResetH asserted one cycle after a read Ack -> no AMisoVld; ARamWrEn=0; the next contention is won by A.

Source files
------------

// File: rtl/ram_dp_arbiter.sv
// Two-requester arbiter/sequencer for a simple dual-port RAM with registered read.
// Independent round-robin on the write and read ports, tagged read return, same-cycle write->read bypass.
module ram_dp_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              AClkH,
    input  logic              AResetH,
    input  logic              AClkHEn,
    input  logic              AReqA,
    input  logic              AWrA,
    input  logic [ADDR_W-1:0] AAddrA,
    input  logic [DATA_W-1:0] AMosiA,
    output logic              AAckA,
    output logic [DATA_W-1:0] AMisoA,
    output logic              AMisoVldA,
    input  logic              AReqB,
    input  logic              AWrB,
    input  logic [ADDR_W-1:0] AAddrB,
    input  logic [DATA_W-1:0] AMosiB,
    output logic              AAckB,
    output logic [DATA_W-1:0] AMisoB,
    output logic              AMisoVldB,
    output logic [ADDR_W-1:0] ARamAddrWr,
    output logic [DATA_W-1:0] ARamMosi,
    output logic              ARamWrEn,
    output logic [ADDR_W-1:0] ARamAddrRd,
    input  logic [DATA_W-1:0] ARamMiso
);

    logic [1:0]        w_req;
    logic [1:0]        w_wr;
    logic [ADDR_W-1:0] w_addr [2];
    logic [DATA_W-1:0] w_mosi [2];
    logic [1:0]        w_wr_cand;
    logic [1:0]        w_rd_cand;
    logic [1:0]        w_wr_gnt;
    logic [1:0]        w_rd_gnt;
    logic              w_wr_sel;
    logic              w_rd_sel;
    logic              w_en;
    logic [1:0]        w_ack;
    logic [1:0]        w_vld;
    logic [DATA_W-1:0] w_miso [2];
    logic [DATA_W-1:0] w_rd_data;

    logic              r_ram_wr_en;
    logic [ADDR_W-1:0] r_ram_addr_wr;
    logic [DATA_W-1:0] r_ram_mosi;
    logic [ADDR_W-1:0] r_ram_addr_rd;
    logic              r_rd_vld1;
    logic              r_tag1;
    logic              r_rd_vld2;
    logic              r_tag2;
    logic              r_byp;
    logic [DATA_W-1:0] r_byp_data;
    logic              r_wr_last;   // 1 = B was last granted
    logic              r_rd_last;

    assign w_req     = {AReqB, AReqA};
    assign w_wr      = {AWrB, AWrA};
    assign w_addr[0] = AAddrA;
    assign w_addr[1] = AAddrB;
    assign w_mosi[0] = AMosiA;
    assign w_mosi[1] = AMosiB;

    assign w_en      = AClkHEn & ~AResetH;
    assign w_wr_cand = w_req & w_wr;
    assign w_rd_cand = w_req & ~w_wr;

    // Under contention the requester that was not granted last wins.
    assign w_wr_gnt[0] = w_en & w_wr_cand[0] & (~w_wr_cand[1] | r_wr_last);
    assign w_wr_gnt[1] = w_en & w_wr_cand[1] & (~w_wr_cand[0] | ~r_wr_last);
    assign w_rd_gnt[0] = w_en & w_rd_cand[0] & (~w_rd_cand[1] | r_rd_last);
    assign w_rd_gnt[1] = w_en & w_rd_cand[1] & (~w_rd_cand[0] | ~r_rd_last);
    assign w_wr_sel    = w_wr_gnt[1];
    assign w_rd_sel    = w_rd_gnt[1];

    assign w_rd_data = r_byp ? r_byp_data : ARamMiso;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign w_ack[gi]  = w_wr_gnt[gi] | w_rd_gnt[gi];
            assign w_vld[gi]  = w_en & r_rd_vld2 & (r_tag2 == 1'(gi));
            assign w_miso[gi] = w_vld[gi] ? w_rd_data : '0;
        end
    endgenerate

    assign AAckA     = w_ack[0];
    assign AAckB     = w_ack[1];
    assign AMisoVldA = w_vld[0];
    assign AMisoVldB = w_vld[1];
    assign AMisoA    = w_miso[0];
    assign AMisoB    = w_miso[1];

    // A registered write is suppressed while stalled or in reset so it is never issued twice or after reset.
    assign ARamWrEn   = r_ram_wr_en & w_en;
    assign ARamAddrWr = r_ram_addr_wr;
    assign ARamMosi   = r_ram_mosi;
    assign ARamAddrRd = r_ram_addr_rd;

    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            r_ram_wr_en   <= 1'b0;
            r_ram_addr_wr <= '0;
            r_ram_mosi    <= '0;
            r_ram_addr_rd <= '0;
            r_rd_vld1     <= 1'b0;
            r_tag1        <= 1'b0;
            r_rd_vld2     <= 1'b0;
            r_tag2        <= 1'b0;
            r_byp         <= 1'b0;
            r_byp_data    <= '0;
            r_wr_last     <= 1'b1;
            r_rd_last     <= 1'b1;
        end else if (AClkHEn) begin
            r_ram_wr_en <= |w_wr_gnt;
            if (|w_wr_gnt) begin
                r_ram_addr_wr <= w_addr[w_wr_sel];
                r_ram_mosi    <= w_mosi[w_wr_sel];
                r_wr_last     <= w_wr_sel;
            end
            r_rd_vld1 <= |w_rd_gnt;
            if (|w_rd_gnt) begin
                r_ram_addr_rd <= w_addr[w_rd_sel];
                r_tag1        <= w_rd_sel;
                r_rd_last     <= w_rd_sel;
            end
            r_rd_vld2 <= r_rd_vld1;
            r_tag2    <= r_tag1;
            // The RAM returns pre-write data when both ports hit one address in the same cycle.
            r_byp     <= r_ram_wr_en & r_rd_vld1 & (r_ram_addr_rd == r_ram_addr_wr);
            if (r_ram_wr_en & r_rd_vld1 & (r_ram_addr_rd == r_ram_addr_wr))
                r_byp_data <= r_ram_mosi;
        end
    end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: directed steps push expected RAM writes and read returns
// into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_dp_arbiter;

    logic       AClkH = 1'b0;
    logic       AResetH, AClkHEn;
    logic       AReqA, AWrA, AReqB, AWrB;
    logic [7:0] AAddrA, AMosiA, AAddrB, AMosiB;
    logic       AAckA, AAckB, AMisoVldA, AMisoVldB;
    logic [7:0] AMisoA, AMisoB;
    logic [7:0] ARamAddrWr, ARamMosi, ARamAddrRd, ARamMiso;
    logic       ARamWrEn;

    always #5 AClkH = ~AClkH;

    ram_dp_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
        .AReqA(AReqA), .AWrA(AWrA), .AAddrA(AAddrA), .AMosiA(AMosiA),
        .AAckA(AAckA), .AMisoA(AMisoA), .AMisoVldA(AMisoVldA),
        .AReqB(AReqB), .AWrB(AWrB), .AAddrB(AAddrB), .AMosiB(AMosiB),
        .AAckB(AAckB), .AMisoB(AMisoB), .AMisoVldB(AMisoVldB),
        .ARamAddrWr(ARamAddrWr), .ARamMosi(ARamMosi), .ARamWrEn(ARamWrEn),
        .ARamAddrRd(ARamAddrRd), .ARamMiso(ARamMiso)
    );

    // RAM model: one write port, registered read (read-before-write on a same-address collision)
    logic [7:0] mem [256];
    logic [7:0] ram_q;
    logic       preloaded = 1'b0;
    assign ARamMiso = ram_q;

    always @(posedge AClkH) begin
        if (!preloaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h30] <= 8'hA0;
            mem[8'h31] <= 8'hA1;
            mem[8'h32] <= 8'hA2;
            mem[8'h40] <= 8'hB4;
            ram_q      <= 8'h00;
            preloaded  <= 1'b1;
        end else begin
            if (ARamWrEn) mem[ARamAddrWr] <= ARamMosi;
            ram_q <= mem[ARamAddrRd];
        end
    end

    int cyc = 0;
    always @(posedge AClkH) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t wrq[$];
    exp_t rdq_a[$];
    exp_t rdq_b[$];

    int errors = 0;
    int checks = 0;
    int gap_extra = 0;
    bit no_push = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic report_bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s @cyc %0d: got event, expected none", name, cyc);
    endtask

    // Drive one cycle of commands, check acks, push expected RAM write / read return.
    task automatic step(input logic ra, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                        input logic rb, input logic wb, input logic [7:0] ab, input logic [7:0] db,
                        input logic ea, input logic eb, input logic [7:0] xa, input logic [7:0] xb);
        exp_t e;
        AReqA = ra; AWrA = wa; AAddrA = aa; AMosiA = da;
        AReqB = rb; AWrB = wb; AAddrB = ab; AMosiB = db;
        @(negedge AClkH);
        check("ackA", 32'(AAckA), 32'(ea));
        check("ackB", 32'(AAckB), 32'(eb));
        $display("cyc %0d: A(req=%0b wr=%0b a=%02h) B(req=%0b wr=%0b a=%02h) ack=%0b%0b",
                 cyc, ra, wa, aa, rb, wb, ab, AAckA, AAckB);
        if (!no_push) begin
            if (ea) begin
                if (wa) begin e.a = aa; e.d = da; e.due = cyc + 1 + gap_extra; wrq.push_back(e); end
                else    begin e.a = aa; e.d = xa; e.due = cyc + 2 + gap_extra; rdq_a.push_back(e); end
            end
            if (eb) begin
                if (wb) begin e.a = ab; e.d = db; e.due = cyc + 1 + gap_extra; wrq.push_back(e); end
                else    begin e.a = ab; e.d = xb; e.due = cyc + 2 + gap_extra; rdq_b.push_back(e); end
            end
        end
        @(posedge AClkH); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input int n);
        AResetH = 1'b1;
        AReqA = 1'b1; AWrA = 1'b1; AReqB = 1'b1; AWrB = 1'b0;
        repeat (n) begin
            @(negedge AClkH);
            check("ackA_in_reset", 32'(AAckA), 0);
            check("ackB_in_reset", 32'(AAckB), 0);
            check("wren_in_reset", 32'(ARamWrEn), 0);
            @(posedge AClkH); #1;
        end
        AResetH = 1'b0;
        AReqA = 1'b0; AReqB = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the queues
    exp_t m_e;
    always @(negedge AClkH) begin
        if (ARamWrEn) begin
            if (wrq.size() == 0) report_bad("unexpected_wr");
            else begin
                m_e = wrq.pop_front();
                check("wr_addr", 32'(ARamAddrWr), 32'(m_e.a));
                check("wr_data", 32'(ARamMosi), 32'(m_e.d));
                check("wr_cycle", cyc, m_e.due);
                $display("cyc %0d: RAM write [%02h] <= %02h", cyc, ARamAddrWr, ARamMosi);
            end
        end else if (wrq.size() > 0 && wrq[0].due < cyc) begin
            m_e = wrq.pop_front();
            check("wr_missing", 0, 1);
        end

        if (AMisoVldA) begin
            if (rdq_a.size() == 0) report_bad("unexpected_vldA");
            else begin
                m_e = rdq_a.pop_front();
                check("misoA", 32'(AMisoA), 32'(m_e.d));
                check("vldA_cycle", cyc, m_e.due);
                $display("cyc %0d: A read [%02h] -> %02h", cyc, m_e.a, AMisoA);
            end
        end else begin
            check("misoA_idle_zero", 32'(AMisoA), 0);
            if (rdq_a.size() > 0 && rdq_a[0].due < cyc) begin
                m_e = rdq_a.pop_front();
                check("vldA_missing", 0, 1);
            end
        end

        if (AMisoVldB) begin
            if (rdq_b.size() == 0) report_bad("unexpected_vldB");
            else begin
                m_e = rdq_b.pop_front();
                check("misoB", 32'(AMisoB), 32'(m_e.d));
                check("vldB_cycle", cyc, m_e.due);
                $display("cyc %0d: B read [%02h] -> %02h", cyc, m_e.a, AMisoB);
            end
        end else begin
            check("misoB_idle_zero", 32'(AMisoB), 0);
            if (rdq_b.size() > 0 && rdq_b[0].due < cyc) begin
                m_e = rdq_b.pop_front();
                check("vldB_missing", 0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        AResetH = 1'b1; AClkHEn = 1'b1;
        AReqA = 1'b0; AWrA = 1'b0; AAddrA = 8'h00; AMosiA = 8'h00;
        AReqB = 1'b0; AWrB = 1'b0; AAddrB = 8'h00; AMosiB = 8'h00;
        @(posedge AClkH); #1;
        do_reset(3);

        // Reset state
        @(negedge AClkH);
        check("rst_wren", 32'(ARamWrEn), 0);
        check("rst_addr_wr", 32'(ARamAddrWr), 0);
        check("rst_mosi", 32'(ARamMosi), 0);
        check("rst_addr_rd", 32'(ARamAddrRd), 0);
        check("rst_vldA", 32'(AMisoVldA), 0);
        check("rst_vldB", 32'(AMisoVldB), 0);
        @(posedge AClkH); #1;

        // Single write then read-back
        step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A, 8'h00);
        idle(3);

        // Write contention, both held: A, B, A, B, then A alone
        do_reset(2);
        step(1, 1, 8'h01, 8'h11, 1, 1, 8'h02, 8'h22, 1, 0, 8'h00, 8'h00);
        step(1, 1, 8'h03, 8'h33, 1, 1, 8'h02, 8'h22, 0, 1, 8'h00, 8'h00);
        step(1, 1, 8'h03, 8'h33, 1, 1, 8'h04, 8'h44, 1, 0, 8'h00, 8'h00);
        step(1, 1, 8'h05, 8'h55, 1, 1, 8'h04, 8'h44, 0, 1, 8'h00, 8'h00);
        step(1, 1, 8'h05, 8'h55, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00);
        idle(2);

        // Same-cycle write and read of one address: bypass returns new data
        step(1, 1, 8'h20, 8'hC3, 1, 0, 8'h20, 8'h00, 1, 1, 8'h00, 8'hC3);
        idle(3);

        // Pipelined reads with contention
        step(1, 0, 8'h30, 8'h00, 1, 0, 8'h40, 8'h00, 1, 0, 8'hA0, 8'h00);
        step(1, 0, 8'h31, 8'h00, 1, 0, 8'h40, 8'h00, 0, 1, 8'h00, 8'hB4);
        step(1, 0, 8'h31, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA1, 8'h00);
        step(1, 0, 8'h32, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA2, 8'h00);
        idle(3);

        // Clock enable low for 3 cycles between ack and return
        gap_extra = 3;
        step(1, 0, 8'h31, 8'h00, 1, 1, 8'h50, 8'h77, 1, 1, 8'hA1, 8'h00);
        gap_extra = 0;
        AClkHEn = 1'b0;
        repeat (3) step(1, 0, 8'h40, 8'h00, 1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
        AClkHEn = 1'b1;
        idle(4);

        // Reset one cycle after acks: in-flight read and write are dropped
        no_push = 1'b1;
        step(1, 0, 8'h30, 8'h00, 1, 1, 8'h60, 8'h99, 1, 1, 8'h00, 8'h00);
        no_push = 1'b0;
        do_reset(2);
        step(1, 1, 8'h61, 8'h12, 1, 1, 8'h62, 8'h34, 1, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h62, 8'h34, 0, 1, 8'h00, 8'h00);
        step(1, 0, 8'h61, 8'h00, 1, 0, 8'h60, 8'h00, 1, 0, 8'h12, 8'h00);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h60, 8'h00, 0, 1, 8'h00, 8'h00);
        idle(5);

        check("queues_drained", 32'(wrq.size() + rdq_a.size() + rdq_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
